// File: rtl/ula_pkg.sv
// Shared definitions for the ULA test driver: opcodes, FSM states and sweep size.
package ula_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_SWP  = 4'h6;
  localparam logic [3:0] OP_SWP2 = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NAND = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  localparam int VEC_COUNT = 128;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;

endpackage

// File: rtl/ula_golden.sv
// Combinational reference model of the ALU; skip flags the undefined divide-by-zero case.
module ula_golden
  import ula_pkg::*;
(
  input  logic [3:0] op,
  input  logic [1:0] a,
  input  logic       b,
  output logic [2:0] expected,
  output logic       skip
);

  always_comb begin
    expected = 3'b000;
    skip     = 1'b0;
    case (op)
      OP_ADD:  expected = {1'b0, a} + {2'b00, b};
      OP_SUB:  expected = {1'b0, a} - {2'b00, b};
      OP_MUL:  expected = {1'b0, (b ? a : 2'b00)};
      // B is one bit, so the only defined quotient is A/1
      OP_DIV: begin
        expected = {1'b0, a};
        skip     = ~b;
      end
      OP_SHL:  expected = {a, 1'b0};
      OP_SHR:  expected = {2'b00, a[1]};
      OP_SWP,
      OP_SWP2: expected = {1'b0, a[0], a[1]};
      OP_AND:  expected = {2'b00, a[0] & b};
      OP_OR:   expected = {2'b00, a[0] | b};
      OP_XOR:  expected = {2'b00, a[0] ^ b};
      OP_NAND: expected = {2'b00, ~(a[0] & b)};
      OP_NOR:  expected = {2'b00, ~(a[0] | b)};
      OP_XNOR: expected = {2'b00, ~(a[0] ^ b)};
      OP_GT:   expected = {2'b00, ({1'b0, a} > {2'b00, b})};
      OP_EQ:   expected = {2'b00, (a == {1'b0, b})};
      default: expected = 3'b000;
    endcase
  end

endmodule

// File: rtl/ula_driver.sv
// Drives an external ALU with a single vector or an exhaustive 128-vector sweep,
// capturing each registered result and flagging mismatches against ula_golden.
module ula_driver
  import ula_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sweep,
  input  logic [3:0] op_in,
  input  logic [1:0] a_in,
  input  logic       b_in,
  output logic [3:0] Sel,
  output logic [1:0] A,
  output logic       B,
  input  logic [2:0] Saida,
  output logic [2:0] result,
  output logic       result_valid,
  output logic       mismatch,
  output logic [7:0] err_cnt,
  output logic       busy,
  output logic       done
);

  state_t     state;
  logic       sweep_mode;
  logic [6:0] idx;
  logic [3:0] op_lat;
  logic [1:0] a_lat;
  logic       b_lat;
  logic [2:0] expected;
  logic       skip;
  logic       miss;

  // Golden value follows the vector currently presented to the ALU
  ula_golden u_golden (
    .op       (Sel),
    .a        (A),
    .b        (B),
    .expected (expected),
    .skip     (skip)
  );

  assign miss = (Saida != expected) && !skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sweep_mode   <= 1'b0;
      idx          <= '0;
      op_lat       <= '0;
      a_lat        <= '0;
      b_lat        <= 1'b0;
      Sel          <= '0;
      A            <= '0;
      B            <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      mismatch     <= 1'b0;
      err_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      mismatch     <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            err_cnt    <= '0;
            sweep_mode <= sweep;
            idx        <= '0;
            op_lat     <= op_in;
            a_lat      <= a_in;
            b_lat      <= b_in;
          end
        end
        ISSUE: begin
          if (sweep_mode) begin
            {Sel, A, B} <= idx;
          end else begin
            Sel <= op_lat;
            A   <= a_lat;
            B   <= b_lat;
          end
          state <= WAIT;
        end
        WAIT: state <= CAPTURE;
        CAPTURE: begin
          result       <= Saida;
          result_valid <= 1'b1;
          mismatch     <= miss;
          if (miss && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          if (!sweep_mode || (idx == 7'(VEC_COUNT - 1))) begin
            state <= DONE;
          end else begin
            idx   <= idx + 7'd1;
            state <= ISSUE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_driver.sv
// Self-checking bench: behavioural ALU (with optional fault on op 1111), scoreboard of captures.
module tb_ula_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sweep;
  logic [3:0] op_in;
  logic [1:0] a_in;
  logic       b_in;
  logic [3:0] Sel;
  logic [1:0] A;
  logic       B;
  logic [2:0] Saida;
  logic [2:0] result;
  logic       result_valid;
  logic       mismatch;
  logic [7:0] err_cnt;
  logic       busy;
  logic       done;

  logic fault = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   rv_cnt = 0;
  int   done_cnt = 0;
  int   last_rv_cyc = 0;

  typedef struct {
    logic [2:0] res;
    logic       mis;
    int         idx;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ula_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sweep        (sweep),
    .op_in        (op_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .Sel          (Sel),
    .A            (A),
    .B            (B),
    .Saida        (Saida),
    .result       (result),
    .result_valid (result_valid),
    .mismatch     (mismatch),
    .err_cnt      (err_cnt),
    .busy         (busy),
    .done         (done)
  );

  // Behavioural ALU; divide by zero deliberately returns 7 so a missing skip shows up
  function automatic logic [2:0] alu_ref(input int sel, input int a, input int b);
    int r;
    int a0;
    a0 = a % 2;
    case (sel)
      0:       r = a + b;
      1:       r = a - b + 8;
      2:       r = a * b;
      3:       r = (b != 0) ? a / b : 7;
      4:       r = a * 2;
      5:       r = a / 2;
      6, 7:    r = a0 * 2 + a / 2;
      8:       r = a0 & b;
      9:       r = a0 | b;
      10:      r = a0 ^ b;
      11:      r = 1 - (a0 & b);
      12:      r = 1 - (a0 | b);
      13:      r = (a0 == b) ? 1 : 0;
      14:      r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    return 3'(r % 8);
  endfunction

  always @(posedge clk)
    Saida <= alu_ref(int'(Sel), int'(A), int'(B)) ^ {2'b00, (fault && (Sel == 4'hF))};

  // Scoreboard monitor: every capture is popped and compared
  always @(negedge clk) begin
    if (result_valid) begin
      rv_cnt++;
      last_rv_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_capture result=%0d mismatch=%0b", result, mismatch);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || mismatch !== e.mis) begin
          errors++;
          $display("FAIL capture_vec%0d got result=%0d mismatch=%0b, want result=%0d mismatch=%0b",
                   e.idx, result, mismatch, e.res, e.mis);
        end
      end
    end
    if (done) done_cnt++;
  end

  task automatic push_vec(input int sel, input int a, input int b, input int id);
    exp_t x;
    logic [2:0] good;
    good  = alu_ref(sel, a, b);
    x.res = good ^ {2'b00, (fault && sel == 15)};
    x.mis = (x.res != good) && !(sel == 3 && b == 0);
    x.idx = id;
    sb.push_back(x);
  endtask

  task automatic do_start(input logic sw, input logic [3:0] op, input logic [1:0] a,
                          input logic b, output int t0);
    @(negedge clk); #1;
    start = 1'b1; sweep = sw; op_in = op; a_in = a; b_in = b;
    @(posedge clk); #1;
    t0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sweep = 1'b0; op_in = '0; a_in = '0; b_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({Sel, A, B, result, result_valid, mismatch, err_cnt, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got Sel=%0d A=%0d B=%0d result=%0d rv=%0b mis=%0b err=%0d busy=%0b done=%0b, want all 0",
               Sel, A, B, result, result_valid, mismatch, err_cnt, busy, done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_single(input logic [3:0] op, input logic [1:0] a, input logic b,
                             input logic [2:0] exp_res);
    int t0;
    int i;
    push_vec(int'(op), int'(a), int'(b), int'(op));
    do_start(1'b0, op, a, b, t0);
    @(negedge clk); #1;
    checks++;
    if (Sel !== op || A !== a || B !== b || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue op=%0d got Sel=%0d A=%0d B=%0d busy=%0b, want %0d %0d %0d 1",
               op, Sel, A, B, busy, op, a, b);
    end
    for (i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL single_timeout op=%0d done never pulsed", op);
    end else begin
      checks++;
      if (cyc - t0 != 4 || last_rv_cyc - t0 != 3) begin
        errors++;
        $display("FAIL single_timing op=%0d got done@%0d valid@%0d, want 4 3",
                 op, cyc - t0, last_rv_cyc - t0);
      end
    end
    checks++;
    if (result !== exp_res || err_cnt !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_result op=%0d got result=%0d err=%0d busy=%0b, want %0d 0 0",
               op, result, err_cnt, busy, exp_res);
    end
    @(negedge clk); #1;
    checks++;
    if (Sel !== op || A !== a || B !== b) begin
      errors++;
      $display("FAIL single_hold op=%0d got Sel=%0d A=%0d B=%0d", op, Sel, A, B);
    end
  endtask

  task automatic test_sweep(input logic f, input logic [7:0] exp_err);
    int t0;
    int rv0;
    int i;
    fault = f;
    for (int k = 0; k < 128; k++) push_vec(k / 8, (k / 2) % 4, k % 2, k);
    rv0 = rv_cnt;
    do_start(1'b1, 4'h0, 2'd0, 1'b0, t0);
    for (i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL sweep_timeout fault=%0b done never pulsed", f);
    end else begin
      checks++;
      if (cyc - t0 != 385) begin
        errors++;
        $display("FAIL sweep_done_cycle fault=%0b got %0d want 385", f, cyc - t0);
      end
    end
    checks++;
    if (rv_cnt - rv0 != 128 || err_cnt !== exp_err || sb.size() != 0) begin
      errors++;
      $display("FAIL sweep_totals fault=%0b got valids=%0d err=%0d left=%0d, want 128 %0d 0",
               f, rv_cnt - rv0, err_cnt, sb.size(), exp_err);
    end
    fault = 1'b0;
  endtask

  task automatic test_abort();
    int t0;
    int rv0;
    int dc;
    int i;
    fault = 1'b0;
    for (int k = 0; k < 128; k++) push_vec(k / 8, (k / 2) % 4, k % 2, k);
    rv0 = rv_cnt;
    do_start(1'b1, 4'h0, 2'd0, 1'b0, t0);
    // start pulses mid-run carry a different single-mode request that must be ignored
    op_in = 4'h5; a_in = 2'd3; b_in = 1'b1;
    for (i = 1; i < 50; i++) begin
      @(negedge clk); #1;
      start = (i == 10 || i == 20);
      sweep = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (rv_cnt - rv0 != 16 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_progress got valids=%0d busy=%0b, want 16 1", rv_cnt - rv0, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    dc = done_cnt;
    #1;
    checks++;
    if ({Sel, A, B, result, result_valid, mismatch, err_cnt, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_reset got Sel=%0d A=%0d B=%0d result=%0d rv=%0b mis=%0b err=%0d busy=%0b done=%0b, want all 0",
               Sel, A, B, result, result_valid, mismatch, err_cnt, busy, done);
    end
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != dc || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done got done_pulses=%0d busy=%0b, want 0 0", done_cnt - dc, busy);
    end
    for (int k = 0; k < 128; k++) push_vec(k / 8, (k / 2) % 4, k % 2, k);
    rv0 = rv_cnt;
    do_start(1'b1, 4'h0, 2'd0, 1'b0, t0);
    @(negedge clk); #1;
    checks++;
    if (Sel !== 4'h0 || A !== 2'd0 || B !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_first_vec got Sel=%0d A=%0d B=%0d busy=%0b, want 0 0 0 1", Sel, A, B, busy);
    end
    for (i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    checks++;
    if (done !== 1'b1 || cyc - t0 != 385 || rv_cnt - rv0 != 128) begin
      errors++;
      $display("FAIL restart_sweep got done=%0b at %0d valids=%0d, want 1 385 128",
               done, cyc - t0, rv_cnt - rv0);
    end
  endtask

  initial begin
    test_reset();
    test_single(4'h0, 2'd3, 1'b1, 3'd4);
    test_single(4'h1, 2'd0, 1'b1, 3'd7);
    test_single(4'h3, 2'd2, 1'b0, 3'd7);
    test_single(4'h6, 2'd2, 1'b0, 3'd1);
    test_single(4'hB, 2'd1, 1'b1, 3'd0);
    test_single(4'hE, 2'd2, 1'b1, 3'd1);
    test_sweep(1'b0, 8'd0);
    test_sweep(1'b1, 8'd8);
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ula_driver.md
ULA_DRIVER -- requirements
Module: ula_driver

Interface
REQ-001 The block SHALL have these ports, in this order: clk, input, 1, single clock, all logic on posedge.
REQ-002 rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 start, input, 1, one-cycle request to begin a run; sampled only in IDLE.
REQ-004 sweep, input, 1, sampled with start: 0 runs a single vector, 1 runs all 128 vectors.
REQ-005 op_in, input, 4, operation code for single mode.
REQ-006 a_in, input, 2, A operand for single mode.
REQ-007 b_in, input, 1, B operand for single mode.
REQ-008 Sel, output, 4, registered operation code driven to the ALU.
REQ-009 A, output, 2, registered A operand driven to the ALU.
REQ-010 B, output, 1, registered B operand driven to the ALU.
REQ-011 Saida, input, 3, ALU result; the ALU registers it one clk after sampling Sel/A/B.
REQ-012 result, output, 3, last captured Saida.
REQ-013 result_valid, output, 1, one-cycle pulse when result updates.
REQ-014 mismatch, output, 1, pulse coincident with result_valid when the capture differs from the expected value.
REQ-015 err_cnt, output, 8, saturating mismatch count for the current run.
REQ-016 busy, output, 1, high in every state except IDLE.
REQ-017 done, output, 1, one-cycle pulse at the end of a run.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, CAPTURE, DONE.
REQ-019 IDLE -> ISSUE SHALL occur when start=1; entering ISSUE SHALL clear err_cnt and latch sweep.
REQ-020 ISSUE SHALL register Sel/A/B, then go to WAIT; WAIT SHALL take one cycle, then go to CAPTURE.
REQ-021 In CAPTURE the block SHALL register result<=Saida, pulse result_valid, and compute mismatch.
REQ-022 After CAPTURE the FSM SHALL go to ISSUE for the next vector, or to DONE after the last one.
REQ-023 DONE SHALL pulse done, then return to IDLE.
REQ-024 Each vector SHALL take exactly 3 cycles; result_valid SHALL pulse 3 cycles after the start edge.
REQ-025 done SHALL pulse 3N+1 cycles after the start edge, for N = 1 (single) or 128 (sweep).
REQ-026 A sweep SHALL use a 7-bit index {Sel,A,B}, running 0..127 in ascending order; single mode SHALL use op_in/a_in/b_in.
REQ-027 start while busy SHALL be ignored.
REQ-028 Expected values SHALL be 3-bit, computed mod 8:
- 0000 A+B; 0001 A-B; 0010 A*B; 0011 A/B.
- 0100 {A,0}; 0101 {00,A[1]}; 0110/0111 {0,A[0],A[1]}.
- 1000..1101 {00, f(A[0],B)}, where f is AND, OR, XOR, NAND, NOR, XNOR.
- 1110 (A>B); 1111 (A==B).
REQ-029 For op 0011 with B=0, compare SHALL be skipped: result is still captured, and mismatch=0.
REQ-030 err_cnt SHALL saturate at 255.
REQ-031 Sel/A/B SHALL hold their last values between vectors and in IDLE.

Reset
REQ-032 Asserting rst_n=0 at any time SHALL force IDLE and clear Sel, A, B, result, result_valid, mismatch, err_cnt, busy, done and the vector index to 0.
REQ-033 After reset mid-run, the next start SHALL begin at vector 0; no done SHALL be emitted for the aborted run.

Structure
REQ-034 Package ula_pkg SHALL hold the 4-bit opcode constants (OP_ADD..OP_EQ), the FSM state enum, and the vector count 128.
REQ-035 The expected-value function SHALL be a combinational sub-module ula_golden (op, a, b -> expected[2:0], skip).
REQ-036 ula_driver SHALL connect directly to a ula instance through Sel/A/B/Saida.

Verification
REQ-037 Single, op 0000, A=3, B=1 -> bench SHALL see Sel=0000, A=11, B=1; result=100 with result_valid at cycle 3; mismatch=0; done at cycle 4.
REQ-038 Single, op 0001, A=0, B=1 -> bench SHALL see result=111, mismatch=0.
REQ-039 Single, op 0011, A=2, B=0 -> bench SHALL see result captured, mismatch=0, err_cnt=0.
REQ-040 Sweep against a correct ula -> bench SHALL see 128 result_valid pulses, err_cnt=0, done at cycle 385.
REQ-041 Sweep against a ula with op 1111 output inverted in bit0 -> bench SHALL see err_cnt=8, mismatch only for indices 120..127.
REQ-042 rst_n low at cycle 50 of a sweep, then start -> bench SHALL see all outputs 0, first Sel=0000, A=00, B=0; start pulses during busy ignored.
